// File: rtl/sat_accumulator.sv
// Streaming packet accumulator: sums beats until in_last, saturating or wrapping
// per beat, and hands the sum, sticky overflow and beat count to a registered output.
module sat_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 6,
  parameter int SIGNED = 1,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sat_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam int EXT_W = ACC_W + 1;

  logic [ACC_W-1:0] acc;
  logic             ovf_st;
  logic [CNT_W-1:0] cnt;

  logic [EXT_W-1:0] data_ext;
  logic [EXT_W-1:0] acc_ext;
  logic [EXT_W-1:0] raw;
  logic [ACC_W-1:0] clamp;
  logic [ACC_W-1:0] nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             ov;
  logic             accept;

  // One guard bit above ACC_W is enough to see overflow of a single addition.
  generate
    if (SIGNED != 0) begin : g_signed
      assign data_ext = {{(EXT_W-DATA_W){in_data[DATA_W-1]}}, in_data};
      assign acc_ext  = {acc[ACC_W-1], acc};
      assign ov       = raw[ACC_W] ^ raw[ACC_W-1];
      assign clamp    = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_unsigned
      assign data_ext = {{(EXT_W-DATA_W){1'b0}}, in_data};
      assign acc_ext  = {1'b0, acc};
      assign ov       = raw[ACC_W];
      assign clamp    = {ACC_W{1'b1}};
    end
  endgenerate

  assign raw     = data_ext + acc_ext;
  assign nxt     = (ov && sat_en) ? clamp : raw[ACC_W-1:0];
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf_st    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      // Handshake drop first so a same-cycle last beat can re-assert out_valid.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clear) begin
        acc    <= '0;
        ovf_st <= 1'b0;
        cnt    <= '0;
      end else if (accept) begin
        if (in_last) begin
          out_sum   <= nxt;
          out_ovf   <= ovf_st | ov;
          out_cnt   <= cnt_inc;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_st    <= 1'b0;
          cnt       <= '0;
        end else begin
          acc    <= nxt;
          ovf_st <= ovf_st | ov;
          cnt    <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: doc/sat_accumulator.md
# sat_accumulator

Parametrised, streaming successor of the 4-bit signed saturating adder. It sums a packet of input beats (terminated by `in_last`) into an `ACC_W`-bit accumulator, either saturating or wrapping per packet beat. It reports the packet sum, a sticky overflow flag and a beat count through a registered valid/ready output. It sits between a sample source and any consumer needing bounded running sums (averagers, energy detectors).

## Interface
- `DATA_W`, 4: input beat width.
- `ACC_W`, 6: accumulator/result width; must be ≥ `DATA_W`.
- `SIGNED`, 1: 1 = two's-complement operands and range; 0 = unsigned.
- `CNT_W`, 4: beat counter width.
- `clk` input 1: clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort of the current partial packet.
- `sat_en` input 1: 1 = saturate, 0 = wrap; sampled per accepted beat.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_data` input `DATA_W`: operand.
- `in_last` input 1: beat closes the packet.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer accepts result.
- `out_sum` output `ACC_W`: packet sum.
- `out_ovf` output 1: some beat in the packet exceeded the `ACC_W` range.
- `out_cnt` output `CNT_W`: beats in packet, saturating at 2^`CNT_W`−1.

## Operation
- State: `acc` (`ACC_W`), `ovf_st` (1), `cnt` (`CNT_W`), output register {`out_valid`, `out_sum`, `out_ovf`, `out_cnt`}.
- Reset (`rst_n`=0, immediate, any time including mid-packet): `acc`=0, `ovf_st`=0, `cnt`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `out_cnt`=0.
- `in_ready` = !`out_valid` || `out_ready`, combinational. It does not depend on `in_valid`.
- A beat is accepted when `in_valid` && `in_ready` && !`clear`.
- Extend `in_data` to `ACC_W`+1 bits: sign-extend if `SIGNED`, else zero-extend. Do the same for `acc`. Add to get `raw`.
- Overflow (`ov`):
  - `SIGNED`=1: `raw` is outside [−2^(`ACC_W`−1), 2^(`ACC_W`−1)−1].
  - `SIGNED`=0: carry out of bit `ACC_W`−1.
- Next value `nxt`:
  - If `ov` && `sat_en`: clamp to the range bound in the direction of `raw`. Signed: max 0b01…1, min 0b10…0. Unsigned: all-ones.
  - Otherwise: `raw[ACC_W-1:0]` (wrap).
  - `ov` is flagged whatever `sat_en` is.
- Accepted non-last beat: `acc`←`nxt`; `ovf_st`←`ovf_st`|`ov`; `cnt`←`cnt`+1, saturating.
- Accepted last beat:
  - `out_sum`←`nxt`; `out_ovf`←`ovf_st`|`ov`; `out_cnt`←`cnt`+1, saturating; `out_valid`←1.
  - `acc`, `ovf_st` and `cnt` go to 0.
- Output handshake: when `out_valid` && `out_ready` and no last beat is accepted in the same cycle, `out_valid`←0. The data registers hold their value.
- `clear`=1: `acc`, `ovf_st` and `cnt` go to 0. Any beat presented that cycle is discarded. The output register and its handshake are unaffected.

## Timing
- Latency: the result appears on `out_valid` the cycle after the last beat is accepted. Throughput is one beat per cycle.
- Back-to-back single-beat packets while `out_ready`=1: `out_valid` stays high and the data updates every cycle.
- Back-pressure: while `out_valid`=1 and `out_ready`=0, `in_ready`=0. The output is stable and the accumulator is frozen.
- Simultaneous output handshake and last-beat acceptance: new result loaded; `out_valid` stays 1.
- `sat_en` takes effect per beat. A wrapped partial sum is not retroactively saturated.
- Reset release: first beat can be accepted in the first cycle `rst_n`=1 (`in_ready`=1).

## Test plan
- **Reference parity** (`DATA_W`=`ACC_W`=4, `SIGNED`=1, `sat_en`=1): single-beat packets (`acc`=0 start) are not enough for this, so use 2-beat packets {a,b}. Cover the full 16×16 grid:
  - Each `out_sum` must equal saturated a+b, e.g. {4,7}→7 with ovf=1, {−4,−7}→−8 with ovf=1, {3,−5}→−2 with ovf=0.
  - `out_cnt`=2 for every packet.
- **Wrap mode** (defaults, `sat_en`=0): packet {7,7,7,7,7} → `out_sum`=35−64=−29 (6'b100011), `out_ovf`=1, `out_cnt`=5.
- **Unsigned mode** (`SIGNED`=0, `sat_en`=1): packet {15,15,15,15,15} → `out_sum`=63, `out_ovf`=1. Packet {1,2} → 3, `out_ovf`=0.
- **Back-pressure**:
  - Hold `out_ready`=0 after packet {3} → `in_ready`=0 and `out_sum` stays 3 for 5 cycles.
  - Raise `out_ready` while presenting last beat {−2} → the next cycle shows `out_sum`=−2 with `out_valid` continuously 1.
- **Clear mid-packet**: beats {5,5}, then `clear`=1 with beat 9 presented, then {1} last → `out_sum`=1, `out_ovf`=0, `out_cnt`=1.
- **Async reset mid-packet**: assert `rst_n`=0 between clock edges after {6,6} with `out_valid`=1 → all outputs 0 immediately. After release, packet {2} → `out_sum`=2.
